scan_mux_nx1: RTL and testbench
===============================

Name: scan_mux_nx1

Overview:
- Parametrised, registered N-to-1 multiplexer.
- Successor to the combinational 8x1 mux; the defaults N=8, W=1 cover the same use.
- Adds channel width W, a per-channel enable mask, out-of-range select detection, and an auto-scan mode that round-robins over enabled channels with a programmable dwell time.
- Feeds downstream logic (display/serial mux, sampling front-end) that needs one channel per slot plus the channel index.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 1, data width per channel.
- DWELL, 4, cycles each channel is held in scan mode (DWELL >= 1).
- SELW, $clog2(N), select/index width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel  input  SELW  channel select, manual mode only.
- ch_en  input  N  per-channel enable mask; bit i enables channel i.
- in  input  N*W  packed channel data; channel i = in[i*W +: W].
- y  output  W  registered selected data.
- y_ch  output  SELW  index of the channel currently driving y.
- y_valid  output  1  y/y_ch carry a valid enabled channel.
- sel_err  output  1  manual sel >= N (only possible when N is not a power of 2).

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset: when rst=1 at a rising edge, y=0, y_ch=0, y_valid=0, sel_err=0, scan pointer p=0, dwell count c=0, state=IDLE. Reset overrides all other inputs, including mid-scan.
- Latency: all outputs are registered, one cycle after the inputs are sampled. No combinational path from inputs to outputs.
- Manual mode (mode=0), per cycle:
  - sel >= N: y=0, y_valid=0, sel_err=1.
  - ch_en[sel]=0: y=0, y_ch=sel, y_valid=0, sel_err=0.
  - Otherwise: y=in[sel], y_ch=sel, y_valid=1, sel_err=0.
  - p and c hold their values.
- Scan mode (mode=1) is an FSM with states IDLE and DWELL. sel_err=0 throughout.
  - IDLE: y=0, y_valid=0, p holds.
    - If ch_en != 0, go to DWELL with p = first enabled index found searching p, p+1, ... mod N; c=0.
  - DWELL: y=in[p] (live data, re-sampled every cycle), y_ch=p, y_valid=1, c increments each cycle.
    - When c==DWELL-1: p = next enabled index searching p+1 ... p+N mod N, and c=0.
    - If only p is enabled, p is unchanged and c restarts at 0.
    - If ch_en[p] drops mid-dwell: the next cycle advances to the next enabled channel with c=0. y_valid stays 1 if another channel is enabled.
    - If ch_en becomes all zero: go to IDLE next cycle; y_valid=0 from that cycle.
- Wrap-around: the search wraps from N-1 to 0. The lowest-index enabled channel follows the highest.
- Mode switches:
  - Manual->scan: enter the IDLE/DWELL evaluation from the held p, with c=0.
  - Scan->manual: p is frozen; manual output takes effect on the next cycle.
- DWELL=1: the channel advances every cycle.
- Only the low SELW bits of sel are used. No X propagation: all outputs are defined every cycle after reset.

Test Plan:
- Manual, N=8, W=1, in=8'b11001100, ch_en=8'hFF, sel sweeps 0..7 (one per cycle) -> y one cycle later = 0,0,1,1,0,0,1,1, y_valid=1, y_ch tracks sel.
- Manual, ch_en=8'hFE, sel=0 -> y=0, y_valid=0, y_ch=0. With N=6, sel=7 -> sel_err=1, y_valid=0.
- Scan, N=8, W=8, DWELL=4, ch_en=8'b00100101, in[i]=8'h10+i -> y_ch sequence 0,0,0,0,2,2,2,2,5,5,5,5,0... with y=8'h10, 8'h12, 8'h15 accordingly (wrap 5->0).
- Scan with ch_en=8'h01 -> y_ch stays 0 indefinitely, y_valid=1. Then set ch_en=0 -> y_valid=0 one cycle later (IDLE). Restore 8'h04 -> y_ch=2, y_valid=1 one cycle later.
- Scan with ch_en=8'h0F; clear bit 1 at c=1 while p=1 -> next cycle y_ch=2, c restarts (channel 2 held 4 cycles).
- Assert rst for 1 cycle mid-dwell on channel 5 -> next cycle all outputs 0. After release with mode=1, ch_en=8'hFF -> y_ch=0 for DWELL cycles, then 1.

Source files
------------

// File: rtl/scan_mux_nx1.sv
// Registered N-to-1 channel multiplexer with a manual select mode and an
// auto-scan mode that round-robins over the enabled channels with a fixed dwell.
module scan_mux_nx1 #(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    ch_en,
  input  logic [N*W-1:0]  in,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] y_ch,
  output logic            y_valid,
  output logic            sel_err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [SELW-1:0] p_r, p_s;
  logic [CW-1:0]   c_r, c_s;
  logic [W-1:0]    y_r, y_s;
  logic [SELW-1:0] y_ch_r, y_ch_s;
  logic            y_valid_r, y_valid_s;
  logic            sel_err_r, sel_err_s;

  logic            sel_oor_s;
  logic [SELW-1:0] p_inc_s;
  logic [SELW-1:0] first_s;
  logic [SELW-1:0] next_s;

  // First enabled index at or after start, wrapping N-1 -> 0.
  function automatic logic [SELW-1:0] find_from(input logic [N-1:0] en,
                                                 input logic [SELW-1:0] start);
    logic [SELW-1:0] r;
    logic [SELW-1:0] idx;
    logic            found;
    int              t;
    r     = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      t = int'(start) + k;
      if (t >= N) t = t - N;
      idx = SELW'(t);
      if (!found && en[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] data,
                                        input logic [SELW-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == SELW'(i)) r = data[i*W +: W];
    end
    return r;
  endfunction

  assign sel_oor_s = (int'(sel) >= N);
  assign p_inc_s   = (p_r == SELW'(N - 1)) ? {SELW{1'b0}} : p_r + SELW'(1);
  assign first_s   = find_from(ch_en, p_r);
  assign next_s    = find_from(ch_en, p_inc_s);

  // Next-state and next-output decode for both modes.
  always_comb begin
    state_s   = state_r;
    p_s       = p_r;
    c_s       = c_r;
    y_s       = {W{1'b0}};
    y_ch_s    = p_r;
    y_valid_s = 1'b0;
    sel_err_s = 1'b0;
    if (!mode) begin
      // Leaving scan always re-enters through IDLE so the dwell restarts.
      state_s = ST_IDLE;
      if (sel_oor_s) begin
        sel_err_s = 1'b1;
        y_ch_s    = {SELW{1'b0}};
      end else if (!ch_en[sel]) begin
        y_ch_s = sel;
      end else begin
        y_s       = pick(in, sel);
        y_ch_s    = sel;
        y_valid_s = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ch_en != {N{1'b0}}) begin
            state_s   = ST_DWELL;
            p_s       = first_s;
            c_s       = {CW{1'b0}};
            y_s       = pick(in, first_s);
            y_ch_s    = first_s;
            y_valid_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (ch_en == {N{1'b0}}) begin
            state_s = ST_IDLE;
          end else if (!ch_en[p_r] || (c_r == CW'(DWELL - 1))) begin
            p_s       = next_s;
            c_s       = {CW{1'b0}};
            y_s       = pick(in, next_s);
            y_ch_s    = next_s;
            y_valid_s = 1'b1;
          end else begin
            c_s       = c_r + CW'(1);
            y_s       = pick(in, p_r);
            y_ch_s    = p_r;
            y_valid_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      p_r       <= {SELW{1'b0}};
      c_r       <= {CW{1'b0}};
      y_r       <= {W{1'b0}};
      y_ch_r    <= {SELW{1'b0}};
      y_valid_r <= 1'b0;
      sel_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      p_r       <= p_s;
      c_r       <= c_s;
      y_r       <= y_s;
      y_ch_r    <= y_ch_s;
      y_valid_r <= y_valid_s;
      sel_err_r <= sel_err_s;
    end
  end

  assign y       = y_r;
  assign y_ch    = y_ch_r;
  assign y_valid = y_valid_r;
  assign sel_err = sel_err_r;

endmodule

// File: tb/tb_scan_mux_nx1.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the 8-channel, 8-bit, dwell-4 configuration.
module tb_scan_mux_nx1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: N=8, W=8, DWELL=4
  logic        rst_a, mode_a;
  logic [2:0]  sel_a;
  logic [7:0]  en_a;
  logic [63:0] in_a;
  logic [7:0]  y_a;
  logic [2:0]  ych_a;
  logic        yv_a, err_a;

  // DUT B: N=6, W=4, DWELL=1
  logic        rst_b, mode_b;
  logic [2:0]  sel_b;
  logic [5:0]  en_b;
  logic [23:0] in_b;
  logic [3:0]  y_b;
  logic [2:0]  ych_b;
  logic        yv_b, err_b;

  scan_mux_nx1 #(.N(8), .W(8), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst_a), .mode(mode_a), .sel(sel_a), .ch_en(en_a), .in(in_a),
    .y(y_a), .y_ch(ych_a), .y_valid(yv_a), .sel_err(err_a));

  scan_mux_nx1 #(.N(6), .W(4), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst_b), .mode(mode_b), .sel(sel_b), .ch_en(en_b), .in(in_b),
    .y(y_b), .y_ch(ych_b), .y_valid(yv_b), .sel_err(err_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model of DUT A: p = channel on show, held = cycles shown so far.
  int         m_p = 0;
  int         m_held = 0;
  bit         m_scan = 1'b0;
  logic [7:0] exp_y = 8'h00;
  int         exp_ch = 0;
  bit         exp_v = 1'b0;
  bit         exp_err = 1'b0;
  bit         exp_chk = 1'b1;

  function automatic int m_search(input logic [7:0] en, input int start);
    for (int k = 0; k < 8; k++) begin
      if (en[(start + k) % 8]) return (start + k) % 8;
    end
    return start;
  endfunction

  task automatic model_update();
    if (rst_a) begin
      m_p = 0; m_held = 0; m_scan = 1'b0;
      exp_y = 8'h00; exp_ch = 0; exp_v = 1'b0; exp_err = 1'b0; exp_chk = 1'b1;
    end else if (!mode_a) begin
      m_scan = 1'b0; exp_err = 1'b0; exp_chk = 1'b1; exp_ch = int'(sel_a);
      exp_v  = en_a[sel_a];
      exp_y  = exp_v ? in_a[int'(sel_a)*8 +: 8] : 8'h00;
    end else begin
      exp_err = 1'b0;
      if (en_a == 8'h00) begin
        m_scan = 1'b0; exp_v = 1'b0; exp_y = 8'h00; exp_chk = 1'b0;
      end else begin
        if (!m_scan) begin
          m_p = m_search(en_a, m_p); m_held = 1; m_scan = 1'b1;
        end else if (!en_a[m_p] || m_held == 4) begin
          m_p = m_search(en_a, (m_p + 1) % 8); m_held = 1;
        end else begin
          m_held++;
        end
        exp_v = 1'b1; exp_y = in_a[m_p*8 +: 8]; exp_ch = m_p; exp_chk = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_ramp_a();
    for (int i = 0; i < 8; i++) in_a[i*8 +: 8] = 8'h10 + 8'(i);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; mode_a = 1'b0; mode_b = 1'b0;
    sel_a = 3'd3; sel_b = 3'd2; en_a = 8'hFF; en_b = 6'h3F;
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 24'hFFFFFF;
    tick();
    checks++;
    if (y_a !== 8'h00 || ych_a !== 3'd0 || yv_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: got y=%h ch=%0d v=%b err=%b expected all zero", y_a, ych_a, yv_a, err_a);
    end
    checks++;
    if (y_b !== 4'h0 || ych_b !== 3'd0 || yv_b !== 1'b0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: got y=%h ch=%0d v=%b err=%b expected all zero", y_b, ych_b, yv_b, err_b);
    end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_manual_sweep();
    logic [7:0] pat;
    pat = 8'b11001100;
    mode_a = 1'b0; en_a = 8'hFF;
    for (int i = 0; i < 8; i++) in_a[i*8 +: 8] = {7'b0, pat[i]};
    for (int s = 0; s < 8; s++) begin
      sel_a = 3'(s);
      tick();
      checks++;
      if (y_a !== {7'b0, pat[s]} || ych_a !== 3'(s) || yv_a !== 1'b1 || err_a !== 1'b0) begin
        errors++;
        $display("FAIL manual_sweep sel=%0d: got y=%h ch=%0d v=%b err=%b expected y=%h ch=%0d v=1 err=0",
                 s, y_a, ych_a, yv_a, err_a, {7'b0, pat[s]}, s);
      end
    end
  endtask

  task automatic test_manual_disabled();
    mode_a = 1'b0; en_a = 8'hFE; sel_a = 3'd0; in_a = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    checks++;
    if (y_a !== 8'h00 || ych_a !== 3'd0 || yv_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL manual_disabled: got y=%h ch=%0d v=%b err=%b expected y=0 ch=0 v=0 err=0",
               y_a, ych_a, yv_a, err_a);
    end
  endtask

  task automatic test_sel_err();
    mode_b = 1'b0; en_b = 6'h3F;
    for (int i = 0; i < 6; i++) in_b[i*4 +: 4] = 4'h5 + 4'(i);
    for (int s = 6; s < 8; s++) begin
      sel_b = 3'(s);
      tick();
      checks++;
      if (err_b !== 1'b1 || yv_b !== 1'b0 || y_b !== 4'h0) begin
        errors++;
        $display("FAIL sel_err sel=%0d: got err=%b v=%b y=%h expected err=1 v=0 y=0", s, err_b, yv_b, y_b);
      end
    end
    sel_b = 3'd3;
    tick();
    checks++;
    if (err_b !== 1'b0 || yv_b !== 1'b1 || y_b !== 4'h8 || ych_b !== 3'd3) begin
      errors++;
      $display("FAIL sel_in_range: got err=%b v=%b y=%h ch=%0d expected err=0 v=1 y=8 ch=3",
               err_b, yv_b, y_b, ych_b);
    end
  endtask

  task automatic test_scan_pattern();
    int seq [13] = '{0, 0, 0, 0, 2, 2, 2, 2, 5, 5, 5, 5, 0};
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    mode_a = 1'b1; en_a = 8'b00100101; set_ramp_a();
    for (int k = 0; k < 13; k++) begin
      tick();
      checks++;
      if (ych_a !== 3'(seq[k]) || y_a !== 8'h10 + 8'(seq[k]) || yv_a !== 1'b1) begin
        errors++;
        $display("FAIL scan_pattern step %0d: got ch=%0d y=%h v=%b expected ch=%0d y=%h v=1",
                 k, ych_a, y_a, yv_a, seq[k], 8'h10 + 8'(seq[k]));
      end
    end
  endtask

  task automatic test_scan_single();
    mode_a = 1'b1; en_a = 8'h01; set_ramp_a();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (ych_a !== 3'd0 || yv_a !== 1'b1 || y_a !== 8'h10) begin
        errors++;
        $display("FAIL scan_single step %0d: got ch=%0d v=%b y=%h expected ch=0 v=1 y=10", k, ych_a, yv_a, y_a);
      end
    end
    en_a = 8'h00;
    tick();
    checks++;
    if (yv_a !== 1'b0 || y_a !== 8'h00) begin
      errors++;
      $display("FAIL scan_all_off: got v=%b y=%h expected v=0 y=0", yv_a, y_a);
    end
    en_a = 8'h04;
    tick();
    checks++;
    if (ych_a !== 3'd2 || yv_a !== 1'b1 || y_a !== 8'h12) begin
      errors++;
      $display("FAIL scan_restore: got ch=%0d v=%b y=%h expected ch=2 v=1 y=12", ych_a, yv_a, y_a);
    end
  endtask

  task automatic test_drop_mid_dwell();
    int seq [11] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3};
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    mode_a = 1'b1; en_a = 8'h0F; set_ramp_a();
    for (int k = 0; k < 11; k++) begin
      if (k == 6) en_a = 8'h0D;
      tick();
      checks++;
      if (ych_a !== 3'(seq[k]) || yv_a !== 1'b1) begin
        errors++;
        $display("FAIL drop_mid_dwell step %0d: got ch=%0d v=%b expected ch=%0d v=1", k, ych_a, yv_a, seq[k]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    mode_a = 1'b1; en_a = 8'hFF; set_ramp_a();
    for (int k = 0; k < 22; k++) tick();
    checks++;
    if (ych_a !== 3'd5 || y_a !== 8'h15) begin
      errors++;
      $display("FAIL reach_ch5: got ch=%0d y=%h expected ch=5 y=15", ych_a, y_a);
    end
    rst_a = 1'b1;
    tick();
    checks++;
    if (y_a !== 8'h00 || ych_a !== 3'd0 || yv_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: got y=%h ch=%0d v=%b err=%b expected all zero", y_a, ych_a, yv_a, err_a);
    end
    rst_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ych_a !== ((k < 4) ? 3'd0 : 3'd1) || yv_a !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_scan step %0d: got ch=%0d v=%b expected ch=%0d v=1",
                 k, ych_a, yv_a, (k < 4) ? 0 : 1);
      end
    end
  endtask

  task automatic test_dwell_one();
    int seq [5] = '{0, 3, 5, 0, 3};
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    mode_b = 1'b1; en_b = 6'b101001;
    for (int i = 0; i < 6; i++) in_b[i*4 +: 4] = 4'h1 + 4'(i);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ych_b !== 3'(seq[k]) || y_b !== 4'h1 + 4'(seq[k]) || yv_b !== 1'b1 || err_b !== 1'b0) begin
        errors++;
        $display("FAIL dwell_one step %0d: got ch=%0d y=%h v=%b err=%b expected ch=%0d y=%h v=1 err=0",
                 k, ych_b, y_b, yv_b, err_b, seq[k], 4'h1 + 4'(seq[k]));
      end
    end
  endtask

  task automatic test_random();
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    mode_a = 1'b1; en_a = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      rst_a = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 24) == 0) mode_a = ~mode_a;
      sel_a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       en_a = 8'h00;
          1:       en_a = 8'h01 << $urandom_range(0, 7);
          default: en_a = 8'($urandom);
        endcase
      end
      in_a = {$urandom, $urandom};
      tick();
      checks++;
      if (y_a !== exp_y || yv_a !== exp_v || err_a !== exp_err ||
          (exp_chk && ych_a !== 3'(exp_ch))) begin
        errors++;
        $display("FAIL random cycle %0d: got y=%h ch=%0d v=%b err=%b expected y=%h ch=%0d v=%b err=%b",
                 n, y_a, ych_a, yv_a, err_a, exp_y, exp_ch, exp_v, exp_err);
      end
    end
    rst_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual_sweep();
    test_manual_disabled();
    test_sel_err();
    test_scan_pattern();
    test_scan_single();
    test_drop_mid_dwell();
    test_reset_mid_scan();
    test_dwell_one();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
